// File: rtl/sdram_stream_reader.sv
// Streaming SDRAM block reader: fetches num_words words per pass (repeat_count+1 passes)
// over the bridge, one read outstanding at a time, and serves them as a valid/ready stream.
module sdram_stream_reader #(
    parameter int ADDR_BITS      = 26,
    parameter int DATA_BITS      = 128,
    parameter int FIFO_DEPTH     = 16,
    parameter int LEN_BITS       = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               start,
    input  logic                               abort,
    input  logic [ADDR_BITS-1:0]               base_address,
    input  logic [LEN_BITS-1:0]                num_words,
    input  logic [7:0]                         repeat_count,
    output logic                               busy,
    output logic                               done,
    output logic                               timeout_error,
    output logic [7:0]                         pass_index,
    output logic [ADDR_BITS-1:0]               interface_address,
    output logic [DATA_BITS/8-1:0]             interface_byte_enable,
    output logic                               interface_read,
    input  logic                               interface_acknowledge,
    input  logic [DATA_BITS-1:0]               interface_read_data,
    output logic [DATA_BITS-1:0]               out_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);
    localparam int BYTES = DATA_BITS / 8;
    localparam int BSH   = $clog2(BYTES);
    localparam int OFF_W = LEN_BITS + BSH;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, DRAIN, DONE, ABORT_WAIT} state_t;

    typedef struct packed {
        logic [ADDR_BITS-1:0] base;
        logic [LEN_BITS-1:0]  num;
        logic [7:0]           rep;
    } job_t;

    state_t               state, state_d;
    job_t                 job;
    logic [LEN_BITS-1:0]  word_idx;
    logic [7:0]           pass_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [TMO_W-1:0]     tmo_cnt;
    logic                 done_q, tmo_q;
    logic                 load, issue, push, adv, flush, set_tmo, pop;
    logic                 tmo_hit, pass_end, last_word;
    logic [OFF_W-1:0]     word_off;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [LVL_W-1:0]     level;

    assign interface_read        = (state == WAIT_ACK) || (state == ABORT_WAIT);
    assign interface_byte_enable = {BYTES{interface_read}};
    assign interface_address     = addr_q;
    assign busy                  = state inside {ISSUE, WAIT_ACK, DRAIN, ABORT_WAIT};
    assign done                  = done_q;
    assign timeout_error         = tmo_q;
    assign pass_index            = pass_q;
    assign fifo_level            = level;
    assign out_valid             = (level != '0);
    assign out_data              = out_valid ? mem[rd_ptr] : '0;
    assign pop                   = out_valid && out_ready;

    assign word_off  = OFF_W'(word_idx) << BSH;
    assign pass_end  = (word_idx == job.num - LEN_BITS'(1));
    assign last_word = pass_end && (pass_q == job.rep);
    assign tmo_hit   = interface_read && !interface_acknowledge &&
                       (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d = state;
        load    = 1'b0;
        issue   = 1'b0;
        push    = 1'b0;
        adv     = 1'b0;
        flush   = 1'b0;
        set_tmo = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    load    = 1'b1;
                    state_d = (num_words == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                // With at most one read in flight, a free slot now guarantees room for its ack.
                if (abort) begin
                    flush   = 1'b1;
                    state_d = IDLE;
                end else if (level < LVL_W'(FIFO_DEPTH)) begin
                    issue   = 1'b1;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (abort) begin
                    if (interface_acknowledge) begin
                        flush   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = ABORT_WAIT;
                    end
                end else if (interface_acknowledge) begin
                    push    = 1'b1;
                    adv     = 1'b1;
                    state_d = last_word ? DRAIN : ISSUE;
                end else if (tmo_hit) begin
                    set_tmo = 1'b1;
                    flush   = 1'b1;
                    state_d = DONE;
                end
            end
            DRAIN: begin
                if (abort) begin
                    flush   = 1'b1;
                    state_d = IDLE;
                end else if (level == '0) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            ABORT_WAIT: begin
                if (interface_acknowledge || tmo_hit) begin
                    set_tmo = !interface_acknowledge;
                    flush   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            job      <= '0;
            word_idx <= '0;
            pass_q   <= '0;
            addr_q   <= '0;
            tmo_cnt  <= '0;
            done_q   <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            done_q <= (state == DONE);
            if (load) begin
                job      <= '{base: base_address, num: num_words, rep: repeat_count};
                word_idx <= '0;
                pass_q   <= '0;
                tmo_q    <= 1'b0;
            end
            if (set_tmo) tmo_q <= 1'b1;
            if (issue)   addr_q <= job.base + ADDR_BITS'(word_off);
            if (adv) begin
                if (pass_end) begin
                    word_idx <= '0;
                    if (!last_word) pass_q <= pass_q + 8'd1;
                end else begin
                    word_idx <= word_idx + LEN_BITS'(1);
                end
            end
            if (interface_read && !interface_acknowledge) tmo_cnt <= tmo_cnt + TMO_W'(1);
            else                                          tmo_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= interface_read_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_stream_reader.sv
// Directed bench for sdram_stream_reader: bridge responder with programmable latency/ack budget,
// stream monitor, and one task per scenario with inline checks.
module tb_sdram_stream_reader;
    localparam int AB = 26, DB = 128, FD = 4, LB = 16, TO = 64;

    logic clk = 0, reset_n = 0, start = 0, abort = 0;
    logic [AB-1:0] base_address = '0;
    logic [LB-1:0] num_words = '0;
    logic [7:0] repeat_count = '0;
    logic busy, done, timeout_error, interface_read, out_valid;
    logic [7:0] pass_index;
    logic [AB-1:0] interface_address;
    logic [DB/8-1:0] interface_byte_enable;
    logic interface_acknowledge = 0;
    logic [DB-1:0] interface_read_data = '0;
    logic [DB-1:0] out_data;
    logic out_ready = 0;
    logic [$clog2(FD+1)-1:0] fifo_level;

    sdram_stream_reader #(.ADDR_BITS(AB), .DATA_BITS(DB), .FIFO_DEPTH(FD), .LEN_BITS(LB),
                          .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .base_address(base_address), .num_words(num_words), .repeat_count(repeat_count),
        .busy(busy), .done(done), .timeout_error(timeout_error), .pass_index(pass_index),
        .interface_address(interface_address), .interface_byte_enable(interface_byte_enable),
        .interface_read(interface_read), .interface_acknowledge(interface_acknowledge),
        .interface_read_data(interface_read_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .fifo_level(fifo_level));

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;
    int ack_delay = 1, ack_budget = -1, ack_cnt = 0;
    int done_cnt = 0, pops_at_done = -1, read_cnt = 0, run = 0, last_run = 0;
    int be_bad = 0, addr_bad = 0;
    logic prev_read = 0;
    logic [AB-1:0] prev_addr = '0;
    logic [AB-1:0] addrq[$];
    logic [7:0] pidxq[$];
    logic [DB-1:0] popq[$];

    function automatic logic [DB-1:0] mk(input logic [AB-1:0] a);
        mk = {32'hD00DFEED, 70'h0, a};
    endfunction

    // bridge responder: acks after ack_delay cycles of read, while ack_budget allows
    initial forever begin
        @(posedge clk); #1;
        if (!reset_n) begin
            interface_acknowledge = 0; ack_cnt = 0;
        end else if (interface_acknowledge) begin
            interface_acknowledge = 0; ack_cnt = 0;
        end else if (interface_read && ack_budget != 0) begin
            ack_cnt++;
            if (ack_cnt >= ack_delay) begin
                interface_acknowledge = 1;
                interface_read_data = mk(interface_address);
                addrq.push_back(interface_address);
                pidxq.push_back(pass_index);
                ack_cnt = 0;
                if (ack_budget > 0) ack_budget--;
            end
        end else begin
            ack_cnt = 0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (out_valid && out_ready) popq.push_back(out_data);
        if (done) begin done_cnt++; pops_at_done = popq.size(); end
        if (interface_read) begin
            read_cnt++; run++;
            if (interface_byte_enable !== '1) be_bad++;
            if (prev_read && interface_address !== prev_addr) addr_bad++;
        end else if (run > 0) begin
            last_run = run; run = 0;
        end
        prev_read = interface_read;
        prev_addr = interface_address;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear();
        popq.delete(); addrq.delete(); pidxq.delete();
        done_cnt = 0; pops_at_done = -1; read_cnt = 0;
    endtask

    task automatic do_start(input logic [AB-1:0] b, input logic [LB-1:0] n, input logic [7:0] r);
        @(posedge clk); #1;
        base_address = b; num_words = n; repeat_count = r; start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int c = 0;
        do begin @(negedge clk); c++; end while (!done && c < budget);
        n_total++;
        if (done !== 1'b1) $display("FAIL %s_done_wait: got no done within %0d cycles", name, budget);
        else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int c = 0;
        do begin @(negedge clk); c++; end while (busy && c < budget);
        n_total++;
        if (busy !== 1'b0) $display("FAIL %s_idle_wait: busy still high after %0d cycles", name, budget);
        else n_pass++;
    endtask

    task automatic test_reset();
        #2;
        n_total++; if (busy !== 0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (done !== 0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
        n_total++; if (timeout_error !== 0) $display("FAIL rst_tmo: got %b want 0", timeout_error); else n_pass++;
        n_total++; if (interface_read !== 0) $display("FAIL rst_read: got %b want 0", interface_read); else n_pass++;
        n_total++; if (interface_byte_enable !== '0) $display("FAIL rst_be: got %h want 0", interface_byte_enable); else n_pass++;
        n_total++; if (interface_address !== '0) $display("FAIL rst_addr: got %h want 0", interface_address); else n_pass++;
        n_total++; if (pass_index !== 0) $display("FAIL rst_pass: got %0d want 0", pass_index); else n_pass++;
        n_total++; if (out_valid !== 0) $display("FAIL rst_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (fifo_level !== 0) $display("FAIL rst_level: got %0d want 0", fifo_level); else n_pass++;
        n_total++; if (out_data !== '0) $display("FAIL rst_data: got %h want 0", out_data); else n_pass++;
        repeat (3) @(posedge clk); #1;
        reset_n = 1;
    endtask

    task automatic test_basic();
        logic [AB-1:0] ea;
        clear(); ack_delay = 3; ack_budget = -1; out_ready = 1;
        do_start(26'h100, 4, 0);
        n_total++; if (busy !== 1) $display("FAIL basic_busy: got %b want 1", busy); else n_pass++;
        wait_done(200, "basic");
        n_total++; if (addrq.size() != 4) $display("FAIL basic_nreads: got %0d want 4", addrq.size()); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            ea = AB'(32'h100 + 16 * k);
            n_total++; if (addrq[k] !== ea) $display("FAIL basic_addr%0d: got %h want %h", k, addrq[k], ea); else n_pass++;
            n_total++; if (popq[k] !== mk(ea)) $display("FAIL basic_data%0d: got %h want %h", k, popq[k], mk(ea)); else n_pass++;
        end
        n_total++; if (popq.size() != 4) $display("FAIL basic_npops: got %0d want 4", popq.size()); else n_pass++;
        n_total++; if (done_cnt != 1) $display("FAIL basic_donecnt: got %0d want 1", done_cnt); else n_pass++;
        n_total++; if (busy !== 0) $display("FAIL basic_busy_after: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_repeat();
        logic [AB-1:0] ea;
        clear(); ack_delay = 2; ack_budget = -1; out_ready = 1;
        do_start(26'h2000, 3, 2);
        wait_done(400, "rep");
        n_total++; if (addrq.size() != 9) $display("FAIL rep_nreads: got %0d want 9", addrq.size()); else n_pass++;
        for (int k = 0; k < 9; k++) begin
            ea = AB'(32'h2000 + 16 * (k % 3));
            n_total++; if (addrq[k] !== ea) $display("FAIL rep_addr%0d: got %h want %h", k, addrq[k], ea); else n_pass++;
            n_total++; if (pidxq[k] !== 8'(k / 3)) $display("FAIL rep_pass%0d: got %0d want %0d", k, pidxq[k], k / 3); else n_pass++;
            n_total++; if (popq[k] !== mk(ea)) $display("FAIL rep_data%0d: got %h want %h", k, popq[k], mk(ea)); else n_pass++;
        end
        n_total++; if (pops_at_done != 9) $display("FAIL rep_pops_at_done: got %0d want 9", pops_at_done); else n_pass++;
        n_total++; if (done_cnt != 1) $display("FAIL rep_donecnt: got %0d want 1", done_cnt); else n_pass++;
    endtask

    task automatic test_wrap();
        clear(); ack_delay = 1; ack_budget = -1; out_ready = 1;
        do_start(26'h3FFFFF0, 2, 0);
        wait_done(100, "wrap");
        n_total++; if (addrq[0] !== 26'h3FFFFF0) $display("FAIL wrap_addr0: got %h want 3fffff0", addrq[0]); else n_pass++;
        n_total++; if (addrq[1] !== 26'h0) $display("FAIL wrap_addr1: got %h want 0", addrq[1]); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [AB-1:0] ea;
        clear(); ack_delay = 1; ack_budget = -1; out_ready = 0;
        do_start(26'h0, 10, 0);
        repeat (40) @(posedge clk); #1;
        n_total++; if (addrq.size() != 4) $display("FAIL bp_nreads: got %0d want 4", addrq.size()); else n_pass++;
        n_total++; if (fifo_level !== 4) $display("FAIL bp_level: got %0d want 4", fifo_level); else n_pass++;
        n_total++; if (interface_read !== 0) $display("FAIL bp_read: got %b want 0", interface_read); else n_pass++;
        n_total++; if (busy !== 1) $display("FAIL bp_busy: got %b want 1", busy); else n_pass++;
        out_ready = 1;
        wait_done(300, "bp");
        n_total++; if (popq.size() != 10) $display("FAIL bp_npops: got %0d want 10", popq.size()); else n_pass++;
        for (int k = 0; k < 10; k++) begin
            ea = AB'(16 * k);
            n_total++; if (popq[k] !== mk(ea)) $display("FAIL bp_data%0d: got %h want %h", k, popq[k], mk(ea)); else n_pass++;
        end
    endtask

    task automatic test_timeout();
        clear(); ack_delay = 1; ack_budget = 1; out_ready = 0;
        do_start(26'h500, 3, 0);
        wait_done(300, "tmo");
        n_total++; if (last_run != TO) $display("FAIL tmo_read_len: got %0d want %0d", last_run, TO); else n_pass++;
        n_total++; if (timeout_error !== 1) $display("FAIL tmo_err: got %b want 1", timeout_error); else n_pass++;
        n_total++; if (fifo_level !== 0) $display("FAIL tmo_flush: got %0d want 0", fifo_level); else n_pass++;
        n_total++; if (done_cnt != 1) $display("FAIL tmo_donecnt: got %0d want 1", done_cnt); else n_pass++;
        n_total++; if (interface_read !== 0) $display("FAIL tmo_read: got %b want 0", interface_read); else n_pass++;
        clear(); ack_budget = -1; out_ready = 1;
        do_start(26'h600, 1, 0);
        n_total++; if (timeout_error !== 0) $display("FAIL tmo_clear: got %b want 0", timeout_error); else n_pass++;
        wait_done(100, "tmo2");
    endtask

    task automatic test_abort();
        clear(); ack_delay = 1; ack_budget = 1; out_ready = 0;
        do_start(26'h700, 4, 0);
        repeat (10) @(posedge clk); #1;
        n_total++; if (fifo_level !== 1) $display("FAIL abort_pre_level: got %0d want 1", fifo_level); else n_pass++;
        abort = 1;
        @(posedge clk); #1;
        abort = 0;
        n_total++; if (interface_read !== 1) $display("FAIL abort_read_held: got %b want 1", interface_read); else n_pass++;
        n_total++; if (busy !== 1) $display("FAIL abort_busy_wait: got %b want 1", busy); else n_pass++;
        repeat (3) @(posedge clk); #1;
        n_total++; if (interface_read !== 1) $display("FAIL abort_read_held2: got %b want 1", interface_read); else n_pass++;
        ack_budget = 1;
        wait_idle(20, "abort");
        @(negedge clk);
        n_total++; if (fifo_level !== 0) $display("FAIL abort_flush: got %0d want 0", fifo_level); else n_pass++;
        n_total++; if (out_valid !== 0) $display("FAIL abort_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (interface_read !== 0) $display("FAIL abort_read_end: got %b want 0", interface_read); else n_pass++;
        n_total++; if (done_cnt != 0) $display("FAIL abort_nodone: got %0d want 0", done_cnt); else n_pass++;
        clear(); ack_budget = -1; out_ready = 1;
        @(posedge clk); #1;
        base_address = 26'h900; num_words = 2; repeat_count = 0; start = 1; abort = 1;
        @(posedge clk); #1;
        start = 0; abort = 0;
        n_total++; if (busy !== 0) $display("FAIL abortstart_busy: got %b want 0", busy); else n_pass++;
        repeat (4) @(posedge clk); #1;
        n_total++; if (read_cnt != 0) $display("FAIL abortstart_reads: got %0d want 0", read_cnt); else n_pass++;
        n_total++; if (done_cnt != 0) $display("FAIL abortstart_done: got %0d want 0", done_cnt); else n_pass++;
    endtask

    task automatic test_zero();
        clear(); ack_budget = -1; out_ready = 1;
        do_start(26'h40, 0, 0);
        @(negedge clk);
        n_total++; if (done !== 0) $display("FAIL zero_done_c1: got %b want 0", done); else n_pass++;
        @(negedge clk);
        n_total++; if (done !== 1) $display("FAIL zero_done_c2: got %b want 1", done); else n_pass++;
        @(negedge clk);
        n_total++; if (done !== 0) $display("FAIL zero_done_c3: got %b want 0", done); else n_pass++;
        n_total++; if (read_cnt != 0) $display("FAIL zero_reads: got %0d want 0", read_cnt); else n_pass++;
    endtask

    task automatic test_start_busy();
        clear(); ack_delay = 1; ack_budget = 0; out_ready = 1;
        do_start(26'h1000, 2, 0);
        repeat (3) @(posedge clk); #1;
        n_total++; if (interface_address !== 26'h1000) $display("FAIL sb_addr0: got %h want 1000", interface_address); else n_pass++;
        do_start(26'h3000, 5, 0);
        repeat (2) @(posedge clk); #1;
        n_total++; if (interface_address !== 26'h1000) $display("FAIL sb_addr_held: got %h want 1000", interface_address); else n_pass++;
        n_total++; if (busy !== 1) $display("FAIL sb_busy: got %b want 1", busy); else n_pass++;
        ack_budget = -1;
        wait_done(100, "sb");
        n_total++; if (addrq.size() != 2) $display("FAIL sb_nreads: got %0d want 2", addrq.size()); else n_pass++;
        n_total++; if (addrq[1] !== 26'h1010) $display("FAIL sb_addr1: got %h want 1010", addrq[1]); else n_pass++;
        n_total++; if (popq.size() != 2) $display("FAIL sb_npops: got %0d want 2", popq.size()); else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        clear(); ack_budget = 0; out_ready = 1;
        do_start(26'h80, 1, 0);
        repeat (3) @(posedge clk); #1;
        n_total++; if (interface_read !== 1) $display("FAIL rmr_read_pre: got %b want 1", interface_read); else n_pass++;
        #2 reset_n = 0;
        #1;
        n_total++; if (interface_read !== 0) $display("FAIL rmr_read: got %b want 0", interface_read); else n_pass++;
        n_total++; if (busy !== 0) $display("FAIL rmr_busy: got %b want 0", busy); else n_pass++;
        @(posedge clk); #1;
        reset_n = 1; ack_budget = -1;
        repeat (3) @(posedge clk); #1;
        n_total++; if (interface_read !== 0) $display("FAIL rmr_idle: got %b want 0", interface_read); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_repeat();
        test_wrap();
        test_backpressure();
        test_timeout();
        test_abort();
        test_zero();
        test_start_busy();
        test_reset_mid_read();
        n_total++; if (be_bad != 0) $display("FAIL byte_enable: got %0d bad cycles want 0", be_bad); else n_pass++;
        n_total++; if (addr_bad != 0) $display("FAIL addr_stable: got %0d changes want 0", addr_bad); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
